cache_req_ctrl: RTL and testbench
=================================

Name: cache_req_ctrl

Overview:
- Request-side controller that sits directly upstream of cache_memory.
- Accepts single-byte CPU read/write requests over a valid/ready handshake and sequences cache_memory's try_read/try_write strobes.
- Policy: write-through, read-allocate. Read misses are filled from main memory over a request/response port, then written into cache_memory. Cache_memory's LRU ages then select the victim way.

Parameters:
- ADDR_W, 32, byte address width (matches cache_memory address_word).
- DATA_W, 8, data width (matches cache_memory write_data/data).
- MEM_TIMEOUT, 255, maximum cycles spent waiting for mem_rsp_valid before an error response is returned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  controller can accept a request.
- cpu_req_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  request address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rsp_valid  out  1  one-cycle response strobe.
- cpu_rsp_err  out  1  qualifies cpu_rsp_valid; memory timeout.
- cpu_rdata  out  DATA_W  read data; 0 for write responses.
- cm_address_word  out  ADDR_W  to cache_memory address_word.
- cm_try_read  out  1  to cache_memory try_read.
- cm_try_write  out  1  to cache_memory try_write.
- cm_write_data  out  DATA_W  to cache_memory write_data.
- cm_data  in  DATA_W  from cache_memory data.
- cm_hit_miss  in  1  from cache_memory hit_miss.
- mem_req_valid  out  1  main-memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rsp_valid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - Every output is 0 except cpu_req_ready, which is 1.
  - Latched request registers and timeout counter clear.
  - A request in flight is dropped with no response.
  - A memory request that was already accepted is not tracked after reset.
- States: IDLE, LOOKUP, COMPARE, CWRITE, MEM_REQ, MEM_WAIT, FILL, RESP.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid&cpu_req_ready, latch addr/we/wdata. Reads go to LOOKUP, writes go to CWRITE.
  - cpu_req_ready=0 in every other state; only one request is outstanding.
- LOOKUP (reads):
  - cm_try_read=1 for exactly one cycle, with cm_address_word = latched address.
  - Next state COMPARE.
- COMPARE:
  - Sample cm_hit_miss and cm_data; cache_memory result is valid the cycle after try_read.
  - Hit: rdata latched, go to RESP.
  - Miss: go to MEM_REQ (mem_we=0).
- CWRITE (writes):
  - cm_try_write=1 for one cycle, cm_write_data = latched wdata.
  - Next state MEM_REQ (mem_we=1, mem_wdata = wdata).
- MEM_REQ:
  - mem_req_valid held at 1 with stable addr/we/wdata until mem_req_ready.
  - On acceptance: writes go to RESP, reads go to MEM_WAIT with the timeout counter cleared.
- MEM_WAIT:
  - Counter increments each cycle.
  - mem_rsp_valid: latch mem_rdata, go to FILL.
  - Counter reaches MEM_TIMEOUT without a response: cpu_rsp_err=1, go to RESP, no fill.
  - mem_rsp_valid in the same cycle as the timeout: the response wins.
- FILL:
  - cm_try_write=1 for one cycle with the fetched byte (allocation into the LRU way).
  - Next state RESP.
- RESP:
  - cpu_rsp_valid=1 for one cycle with cpu_rdata (0 on write or error).
  - Next state IDLE.
- Output timing and invariants:
  - cm_* and mem_* are Moore outputs decoded from registered state.
  - cpu_rsp_* are registered.
  - cm_try_read and cm_try_write are never 1 together.
  - mem_rsp_valid outside MEM_WAIT is ignored.
- Latency, counted from the acceptance edge:
  - Read hit: response visible 3 cycles later.
  - Write: 3 + (MEM_REQ stall) cycles.
  - Read miss: 5 + stall + memory latency cycles.

Optional Feature:
- Macro: CACHE_REQ_STATS_EN.
- When defined, adds outputs stat_hits[31:0], stat_misses[31:0] and stat_timeouts[15:0], plus input stat_clr.
- Counting rules:
  - Hits/misses increment in COMPARE.
  - Timeouts increment on error.
  - Counters saturate at all-ones.
  - stat_clr clears them synchronously; an increment in the same cycle is lost.
  - rst clears them.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cache_pkg holds:
  - the state enum;
  - ADDR_W/DATA_W defaults;
  - a request struct (addr, we, wdata).
- One sub-module, cache_req_timeout: a loadable down-counter with expire flag, used in MEM_WAIT.

Test Plan:
- Read miss, then read hit:
  - Read 0x0000_0040, mem returns 0xA5 after 4 cycles → rsp 0xA5, err=0, FILL strobes cm_try_write.
  - Repeat read → hit, rsp 0xA5 exactly 3 cycles after accept, no mem_req_valid.
- Write-through: write 0x0000_0080 ← 0x3C with mem_req_ready low for 5 cycles → cm_try_write one cycle, mem_req_valid held stable 5 cycles, rsp rdata=0.
- Timeout: read miss, mem never responds → cpu_rsp_err=1 at wait cycle 255, no FILL, controller back in IDLE (ready=1).
- Boundary: mem_rsp_valid arriving on the timeout cycle → data 0x5A returned, err=0.
- Reset mid-operation: rst asserted during MEM_WAIT → outputs 0 and ready=1 immediately (asynchronous). A later stray mem_rsp_valid produces no response.
- Back-to-back: cpu_req_valid held high for 4 requests → each accepted only in IDLE, responses in order. cm_try_read and cm_try_write are never high together.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the cache request controller: FSM states, default widths and
// the latched CPU request.
package cache_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCompare,
    StCwrite,
    StMemReq,
    StMemWait,
    StFill,
    StResp
  } state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [DataWidth-1:0] wdata;
  } req_t;

endpackage

// File: rtl/cache_req_ctrl_if.sv
// CPU, cache_memory and main-memory signals of the request controller.
// slave is the controller's view, master the surrounding system's view.
interface cache_req_ctrl_if
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWidth,
  parameter int unsigned DATA_W = DataWidth
);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_rsp_valid;
  logic              cpu_rsp_err;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] cm_address_word;
  logic              cm_try_read;
  logic              cm_try_write;
  logic [DATA_W-1:0] cm_write_data;
  logic [DATA_W-1:0] cm_data;
  logic              cm_hit_miss;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_addr, cpu_wdata, cm_data, cm_hit_miss,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, cpu_rdata, cm_address_word,
           cm_try_read, cm_try_write, cm_write_data, mem_req_valid, mem_we, mem_addr,
           mem_wdata
  );

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_addr, cpu_wdata, cm_data, cm_hit_miss,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, cpu_rdata, cm_address_word,
           cm_try_read, cm_try_write, cm_write_data, mem_req_valid, mem_we, mem_addr,
           mem_wdata
  );
endinterface

// File: rtl/cache_req_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
module cache_req_timeout #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             expired
);
  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);
endmodule

// File: rtl/cache_req_ctrl.sv
// Write-through, read-allocate request controller in front of cache_memory.
// Define CACHE_REQ_STATS_EN to add hit/miss/timeout statistics counters.
module cache_req_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W      = AddrWidth,
  parameter int unsigned DATA_W      = DataWidth,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef CACHE_REQ_STATS_EN
  input  logic                 stat_clr,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_misses,
  output logic [15:0]          stat_timeouts,
`endif
  cache_req_ctrl_if.slave      bus
);
  localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              tmo_load, tmo_en, tmo_expired;
  logic [ADDR_W-1:0] addr;

  assign addr = req_q.addr;

  // Loaded with MEM_TIMEOUT-1 so MEM_WAIT lasts at most MEM_TIMEOUT cycles.
  cache_req_timeout #(
    .Width (TmoW)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (TmoW'(MEM_TIMEOUT - 1)),
    .en       (tmo_en),
    .expired  (tmo_expired)
  );

  always_comb begin
    state_d             = state_q;
    req_d               = req_q;
    data_d              = data_q;
    err_d               = err_q;
    tmo_load            = 1'b0;
    tmo_en              = 1'b0;
    bus.cpu_req_ready   = 1'b0;
    bus.cm_address_word = '0;
    bus.cm_try_read     = 1'b0;
    bus.cm_try_write    = 1'b0;
    bus.cm_write_data   = '0;
    bus.mem_req_valid   = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_wdata       = '0;
    unique case (state_q)
      StIdle: begin
        bus.cpu_req_ready = 1'b1;
        if (bus.cpu_req_valid) begin
          req_d   = '{addr: bus.cpu_addr, we: bus.cpu_req_we, wdata: bus.cpu_wdata};
          data_d  = '0;
          err_d   = 1'b0;
          state_d = bus.cpu_req_we ? StCwrite : StLookup;
        end
      end
      StLookup: begin
        bus.cm_try_read     = 1'b1;
        bus.cm_address_word = addr;
        state_d             = StCompare;
      end
      StCompare: begin
        if (bus.cm_hit_miss) begin
          data_d  = bus.cm_data;
          state_d = StResp;
        end else begin
          state_d = StMemReq;
        end
      end
      StCwrite: begin
        bus.cm_try_write    = 1'b1;
        bus.cm_address_word = addr;
        bus.cm_write_data   = req_q.wdata;
        state_d             = StMemReq;
      end
      StMemReq: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = req_q.we;
        bus.mem_addr      = addr;
        bus.mem_wdata     = req_q.we ? req_q.wdata : '0;
        if (bus.mem_req_ready) begin
          tmo_load = !req_q.we;
          state_d  = req_q.we ? StResp : StMemWait;
        end
      end
      StMemWait: begin
        tmo_en = 1'b1;
        // A response in the expiry cycle still wins over the timeout.
        if (bus.mem_rsp_valid) begin
          data_d  = bus.mem_rdata;
          state_d = StFill;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StFill: begin
        bus.cm_try_write    = 1'b1;
        bus.cm_address_word = addr;
        bus.cm_write_data   = data_q;
        state_d             = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      req_q       <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      data_q      <= data_d;
      err_q       <= err_d;
      rsp_valid_q <= (state_q == StResp);
      rsp_err_q   <= (state_q == StResp) && err_q;
      rsp_data_q  <= ((state_q == StResp) && !err_q && !req_q.we) ? data_q : '0;
    end
  end

  assign bus.cpu_rsp_valid = rsp_valid_q;
  assign bus.cpu_rsp_err   = rsp_err_q;
  assign bus.cpu_rdata     = rsp_data_q;

`ifdef CACHE_REQ_STATS_EN
  logic hit_evt, miss_evt, tmo_evt;

  assign hit_evt  = (state_q == StCompare) && bus.cm_hit_miss;
  assign miss_evt = (state_q == StCompare) && !bus.cm_hit_miss;
  assign tmo_evt  = (state_q == StMemWait) && !bus.mem_rsp_valid && tmo_expired;

  // Clear takes priority; a coincident increment is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits     <= '0;
      stat_misses   <= '0;
      stat_timeouts <= '0;
    end else if (stat_clr) begin
      stat_hits     <= '0;
      stat_misses   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (hit_evt && (stat_hits != '1))     stat_hits     <= stat_hits + 1'b1;
      if (miss_evt && (stat_misses != '1))  stat_misses   <= stat_misses + 1'b1;
      if (tmo_evt && (stat_timeouts != '1)) stat_timeouts <= stat_timeouts + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed bench for cache_req_ctrl with a small behavioural cache_memory model.
module tb_cache_req_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t_acc = 0;
  int   lat;

  int   rd_cnt = 0, wr_cnt = 0, both_cnt = 0, memv_cnt = 0, unstable = 0;
  int   rsp_cnt = 0, acc_cnt = 0;
  logic [31:0] wr_addr, mem_addr_first;
  logic [7:0]  wr_data, mem_wdata_first;
  logic        mem_we_first;
  logic        memv_prev = 1'b0;
  logic [40:0] mem_prev;
  logic [7:0]  rsp_q[$];
  logic [7:0]  cmem[logic [31:0]];

  int s_wr, s_rd, s_memv, s_uns, s_rsp, s_acc, n0;

  cache_req_ctrl_if bus ();

`ifdef CACHE_REQ_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_hits, stat_misses;
  logic [15:0] stat_timeouts;
`endif

  cache_req_ctrl dut (
    .clk           (clk),
    .rst           (rst),
`ifdef CACHE_REQ_STATS_EN
    .stat_clr      (stat_clr),
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses),
    .stat_timeouts (stat_timeouts),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cpu_req_valid && bus.cpu_req_ready) acc_cnt <= acc_cnt + 1;
  end

  // cache_memory stand-in: result valid the cycle after try_read.
  always @(posedge clk) begin
    bus.cm_hit_miss <= bus.cm_try_read && (cmem.exists(bus.cm_address_word) != 0);
    bus.cm_data     <= (bus.cm_try_read && (cmem.exists(bus.cm_address_word) != 0)) ?
                       cmem[bus.cm_address_word] : 8'h00;
    if (bus.cm_try_write) cmem[bus.cm_address_word] = bus.cm_write_data;
  end

  always @(negedge clk) begin
    if (bus.cm_try_read) rd_cnt++;
    if (bus.cm_try_write) begin
      wr_cnt++;
      wr_addr = bus.cm_address_word;
      wr_data = bus.cm_write_data;
    end
    if (bus.cm_try_read && bus.cm_try_write) both_cnt++;
    if (bus.mem_req_valid) begin
      memv_cnt++;
      if (!memv_prev) begin
        mem_addr_first  = bus.mem_addr;
        mem_we_first    = bus.mem_we;
        mem_wdata_first = bus.mem_wdata;
      end else if (mem_prev != {bus.mem_addr, bus.mem_we, bus.mem_wdata}) begin
        unstable++;
      end
      mem_prev = {bus.mem_addr, bus.mem_we, bus.mem_wdata};
    end
    memv_prev = bus.mem_req_valid;
    if (bus.cpu_rsp_valid) begin
      rsp_cnt++;
      rsp_q.push_back(bus.cpu_rdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic we, input logic [31:0] a, input logic [7:0] d);
    bus.cpu_req_we = we;
    bus.cpu_addr = a;
    bus.cpu_wdata = d;
    bus.cpu_req_valid = 1'b1;
    for (int i = 0; i < 40 && !bus.cpu_req_ready; i++) @(negedge clk);
    chk("req_ready", bus.cpu_req_ready, 1);
    @(negedge clk);
    t_acc = cyc;
    bus.cpu_req_valid = 1'b0;
  endtask

  task automatic mem_serve(input int stall, input int mlat, input logic [7:0] d,
                           input bit respond);
    for (int i = 0; i < 40 && !bus.mem_req_valid; i++) @(negedge clk);
    chk("mem_req_seen", bus.mem_req_valid, 1);
    repeat (stall) @(negedge clk);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    if (respond) begin
      repeat (mlat - 1) @(negedge clk);
      bus.mem_rdata = d;
      bus.mem_rsp_valid = 1'b1;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata = 8'h00;
    end
  endtask

  task automatic wait_rsp(input string tag, input int max, output int l);
    for (int i = 0; i < max && !bus.cpu_rsp_valid; i++) @(negedge clk);
    chk({tag, "_rsp_seen"}, bus.cpu_rsp_valid, 1);
    l = cyc - t_acc;
  endtask

  initial begin
    rst = 1'b1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.cpu_req_ready, 1);
    chk("rst_rsp_valid", bus.cpu_rsp_valid, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_try_read", bus.cm_try_read, 0);
    chk("rst_mem_req", bus.mem_req_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Read miss filled from memory after 4 wait cycles.
    s_wr = wr_cnt;
    send(1'b0, 32'h40, 8'h00);
    mem_serve(0, 4, 8'hA5, 1'b1);
    wait_rsp("miss", 40, lat);
    chk("miss_lat", lat, 9);
    chk("miss_data", bus.cpu_rdata, 32'hA5);
    chk("miss_err", bus.cpu_rsp_err, 0);
    chk("miss_fill_cnt", wr_cnt - s_wr, 1);
    chk("miss_fill_addr", wr_addr, 32'h40);
    chk("miss_fill_data", wr_data, 32'hA5);

    // Same address now hits.
    s_rd = rd_cnt;
    s_memv = memv_cnt;
    send(1'b0, 32'h40, 8'h00);
    wait_rsp("hit", 20, lat);
    chk("hit_lat", lat, 3);
    chk("hit_data", bus.cpu_rdata, 32'hA5);
    chk("hit_err", bus.cpu_rsp_err, 0);
    chk("hit_no_mem", memv_cnt - s_memv, 0);
    chk("hit_one_read", rd_cnt - s_rd, 1);

    // Write-through with 5 stalled request cycles.
    s_wr = wr_cnt;
    s_memv = memv_cnt;
    s_uns = unstable;
    send(1'b1, 32'h80, 8'h3C);
    mem_serve(5, 0, 8'h00, 1'b0);
    wait_rsp("wr", 20, lat);
    chk("wr_lat", lat, 8);
    chk("wr_rdata", bus.cpu_rdata, 0);
    chk("wr_err", bus.cpu_rsp_err, 0);
    chk("wr_cm_cnt", wr_cnt - s_wr, 1);
    chk("wr_memv_cycles", memv_cnt - s_memv, 6);
    chk("wr_mem_stable", unstable - s_uns, 0);
    chk("wr_mem_addr", mem_addr_first, 32'h80);
    chk("wr_mem_we", mem_we_first, 1);
    chk("wr_mem_wdata", mem_wdata_first, 32'h3C);

    // Memory never answers: error after 255 wait cycles.
    s_wr = wr_cnt;
    send(1'b0, 32'h100, 8'h00);
    mem_serve(0, 0, 8'h00, 1'b0);
    wait_rsp("tmo", 300, lat);
    chk("tmo_lat", lat, 259);
    chk("tmo_err", bus.cpu_rsp_err, 1);
    chk("tmo_rdata", bus.cpu_rdata, 0);
    chk("tmo_no_fill", wr_cnt - s_wr, 0);
    chk("tmo_idle_ready", bus.cpu_req_ready, 1);

    // Response on the final wait cycle beats the timeout.
    s_wr = wr_cnt;
    send(1'b0, 32'h140, 8'h00);
    mem_serve(0, 255, 8'h5A, 1'b1);
    wait_rsp("edge", 40, lat);
    chk("edge_lat", lat, 260);
    chk("edge_data", bus.cpu_rdata, 32'h5A);
    chk("edge_err", bus.cpu_rsp_err, 0);
    chk("edge_fill", wr_cnt - s_wr, 1);

    // Asynchronous reset while waiting on memory.
    send(1'b0, 32'h200, 8'h00);
    mem_serve(0, 0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", bus.cpu_req_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", bus.cpu_req_ready, 1);
    chk("arst_rsp_valid", bus.cpu_rsp_valid, 0);
    chk("arst_try_write", bus.cm_try_write, 0);
    chk("arst_mem_req", bus.mem_req_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    s_rsp = rsp_cnt;
    s_wr = wr_cnt;
    @(negedge clk);
    bus.mem_rdata = 8'h77;
    bus.mem_rsp_valid = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata = 8'h00;
    repeat (10) @(negedge clk);
    chk("stray_no_rsp", rsp_cnt - s_rsp, 0);
    chk("stray_no_fill", wr_cnt - s_wr, 0);
    chk("stray_ready", bus.cpu_req_ready, 1);

    // Back-to-back requests with valid held high.
    bus.mem_req_ready = 1'b1;
    s_acc = acc_cnt;
    n0 = rsp_q.size();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin bus.cpu_req_we = 1'b0; bus.cpu_addr = 32'h40;  bus.cpu_wdata = 8'h00; end
        1: begin bus.cpu_req_we = 1'b1; bus.cpu_addr = 32'h300; bus.cpu_wdata = 8'h11; end
        2: begin bus.cpu_req_we = 1'b0; bus.cpu_addr = 32'h300; bus.cpu_wdata = 8'h00; end
        default: begin bus.cpu_req_we = 1'b0; bus.cpu_addr = 32'h80; bus.cpu_wdata = 8'h00; end
      endcase
      bus.cpu_req_valid = 1'b1;
      for (int k = 0; k < 40 && !bus.cpu_req_ready; k++) @(negedge clk);
      @(negedge clk);
    end
    bus.cpu_req_valid = 1'b0;
    for (int k = 0; k < 60 && (rsp_q.size() < n0 + 4); k++) @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("b2b_rsp_count", rsp_q.size() - n0, 4);
    chk("b2b_accepts", acc_cnt - s_acc, 4);
    if (rsp_q.size() >= n0 + 4) begin
      chk("b2b_rsp0", rsp_q[n0],     32'hA5);
      chk("b2b_rsp1", rsp_q[n0 + 1], 32'h00);
      chk("b2b_rsp2", rsp_q[n0 + 2], 32'h11);
      chk("b2b_rsp3", rsp_q[n0 + 3], 32'h3C);
    end
    chk("never_rd_and_wr", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
